// File: rtl/video_stream_pkg.sv
// Shared types and defaults for the camera-to-stream packetizer.
// The FIFO entry carries the packet framing flags alongside each pixel.
package video_stream_pkg;

  localparam int unsigned DATA_WIDTH     = 12;
  localparam int unsigned IMG_WIDTH_DEF  = 320;
  localparam int unsigned IMG_HEIGHT_DEF = 240;
  localparam int unsigned CNT_WIDTH      = 17;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FLUSH
  } wr_state_e;

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO of framed pixel entries.
// Full is judged on current occupancy only; a same-cycle pop never frees a slot for a push.
module stream_fifo
  import video_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output fifo_entry_t head
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  fifo_entry_t      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
    head = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/video_stream_packetizer.sv
// Frames a raw camera pixel strobe into sop/eop-delimited stream packets.
// A truncated frame is always closed with a zero-data eop filler so downstream sees a well-formed packet.
module video_stream_packetizer
  import video_stream_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned DATA_WIDTH = video_stream_pkg::DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start_in,
  input  logic                  pixel_valid_in,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  startofpacket_out,
  output logic                  endofpacket_out,
  output logic                  frame_error_out
);

  localparam logic [CNT_WIDTH-1:0] LAST_PIX = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

  wr_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 push, pop, full, empty;
  fifo_entry_t          push_data, head;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    push      = 1'b0;
    push_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start_in) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // A frame_start takes precedence over a coincident pixel, which is dropped.
        if (frame_start_in) begin
          if (cnt_q != '0) begin
            err_d   = 1'b1;
            state_d = ST_FLUSH;
          end
        end else if (pixel_valid_in) begin
          if (full) begin
            err_d   = 1'b1;
            state_d = (cnt_q == '0) ? ST_IDLE : ST_FLUSH;
          end else begin
            push           = 1'b1;
            push_data.sop  = (cnt_q == '0);
            push_data.eop  = (cnt_q == LAST_PIX);
            push_data.data = pixel_in;
            cnt_d          = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == LAST_PIX) state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (!full) begin
          push          = 1'b1;
          push_data.eop = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  stream_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  always_comb begin
    pop               = !empty && ready_in;
    valid_out         = !empty;
    data_out          = empty ? '0 : head.data;
    startofpacket_out = !empty && head.sop;
    endofpacket_out   = !empty && head.eop;
    frame_error_out   = err_q;
  end

endmodule

// File: tb/tb_video_stream_packetizer.sv
// Scoreboard bench for video_stream_packetizer with a reduced 20x6 frame.
// A frame-level reference model predicts beats and error pulses; a monitor checks every transfer.
module tb_video_stream_packetizer;

  localparam int unsigned W     = 20;
  localparam int unsigned H     = 6;
  localparam int unsigned NPIX  = W * H;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start_in = 1'b0;
  logic          pixel_valid_in = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          ready_in = 1'b0;
  logic          valid_out, startofpacket_out, endofpacket_out, frame_error_out;
  logic [DW-1:0] data_out;

  typedef struct {
    bit            sop;
    bit            eop;
    logic [DW-1:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          occ = 0;
  bit          err_exp = 1'b0;
  bit          in_frame = 1'b0;
  bit          owe_filler = 1'b0;
  int unsigned idx = 0;

  int total = 0;
  int bad = 0;
  int beats = 0;
  int err_seen = 0;
  int sop_seen = 0;

  video_stream_packetizer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frame_start_in   (frame_start_in),
    .pixel_valid_in   (pixel_valid_in),
    .pixel_in         (pixel_in),
    .ready_in         (ready_in),
    .valid_out        (valid_out),
    .data_out         (data_out),
    .startofpacket_out(startofpacket_out),
    .endofpacket_out  (endofpacket_out),
    .frame_error_out  (frame_error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks frame progress and queue occupancy at each clock edge.
  initial forever begin
    bit    full, pop, push, err;
    beat_t e;
    @(posedge clk or posedge reset);
    if (reset) begin
      occ = 0; exp_q.delete(); in_frame = 0; owe_filler = 0; idx = 0; err_exp = 0;
    end else begin
      full = (occ == DEPTH);
      pop  = (occ != 0) && ready_in;
      push = 0;
      err  = 0;
      e    = '{sop: 0, eop: 0, data: '0};
      if (owe_filler) begin
        if (!full) begin
          push = 1; e.eop = 1; owe_filler = 0;
        end
      end else if (in_frame) begin
        if (frame_start_in) begin
          if (idx > 0) begin
            err = 1; in_frame = 0; owe_filler = 1;
          end
        end else if (pixel_valid_in) begin
          if (full) begin
            err = 1; in_frame = 0; owe_filler = (idx > 0);
          end else begin
            push = 1;
            e.sop = (idx == 0);
            e.eop = (idx == NPIX - 1);
            e.data = pixel_in;
            idx++;
            if (idx == NPIX) in_frame = 0;
          end
        end
      end else if (frame_start_in) begin
        in_frame = 1; idx = 0;
      end
      if (push) exp_q.push_back(e);
      occ = occ + int'(push) - int'(pop);
      err_exp = err;
    end
  end

  // Monitor: samples on the falling edge, compares transfers against the scoreboard.
  initial forever begin
    bit              hold_pend;
    logic [DW+1:0]   held;
    beat_t           e;
    @(negedge clk);
    if (reset) begin
      hold_pend = 0;
      chk("rst_valid", valid_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_sop", startofpacket_out, 0);
      chk("rst_eop", endofpacket_out, 0);
      chk("rst_err", frame_error_out, 0);
    end else begin
      chk("valid", valid_out, occ != 0);
      chk("frame_error", frame_error_out, err_exp);
      if (frame_error_out) err_seen++;
      if (hold_pend) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_head", {startofpacket_out, endofpacket_out, data_out}, held);
      end
      if (valid_out && ready_in) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_sop", startofpacket_out, e.sop);
          chk("beat_eop", endofpacket_out, e.eop);
          chk("beat_data", data_out, e.data);
        end
        beats++;
        if (startofpacket_out) sop_seen++;
      end
      hold_pend = valid_out && !ready_in;
      held = {startofpacket_out, endofpacket_out, data_out};
    end
  end

  task automatic cyc(input bit fs, input bit pv, input logic [DW-1:0] px, input bit rdy);
    frame_start_in = fs;
    pixel_valid_in = pv;
    pixel_in       = px;
    ready_in       = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    frame_start_in = 0;
    pixel_valid_in = 0;
    ready_in       = 1;
    while ((occ != 0 || owe_filler) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("drain_bound", n < 500, 1);
  endtask

  task automatic clear_counts();
    beats = 0; err_seen = 0; sop_seen = 0;
  endtask

  task automatic clean_frame(input bit gaps);
    cyc(1, 0, '0, 1);
    for (int unsigned i = 0; i < NPIX; i++) begin
      if (gaps) while ($urandom_range(3) == 0) cyc(0, 0, DW'($urandom), 1);
      cyc(0, 1, DW'(i % 4096), 1);
    end
    drain();
  endtask

  initial begin
    #1;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;

    // nominal frame
    clear_counts();
    clean_frame(0);
    chk("nom_beats", beats, NPIX);
    chk("nom_sops", sop_seen, 1);
    chk("nom_errs", err_seen, 0);

    // backpressure: ready toggles, pixels on alternate cycles
    clear_counts();
    cyc(1, 0, '0, 1);
    for (int unsigned i = 0; i < NPIX; i++) begin
      cyc(0, 1, DW'($urandom), 0);
      cyc(0, 0, '0, 1);
    end
    drain();
    chk("bp_beats", beats, NPIX);
    chk("bp_errs", err_seen, 0);

    // overflow: ready drops at pixel 5, pixels continue
    clear_counts();
    cyc(1, 0, '0, 1);
    for (int unsigned i = 0; i < 25; i++) cyc(0, 1, DW'(i + 100), i < 5);
    beats = 0;
    drain();
    chk("ovf_beats_after_ready", beats, 17);
    chk("ovf_errs", err_seen, 1);
    clear_counts();
    clean_frame(1);
    chk("post_ovf_beats", beats, NPIX);
    chk("post_ovf_errs", err_seen, 0);

    // overflow on the very first pixel of a frame
    clear_counts();
    cyc(1, 0, '0, 1);
    for (int unsigned i = 0; i < NPIX; i++) cyc(0, 1, DW'(i), i < NPIX - 15);
    chk("first_ovf_prefill_errs", err_seen, 0);
    clear_counts();
    cyc(1, 0, '0, 0);
    cyc(0, 1, DW'(777), 0);
    cyc(0, 0, '0, 0);
    drain();
    chk("first_ovf_errs", err_seen, 1);
    chk("first_ovf_beats", beats, 16);
    chk("first_ovf_sops", sop_seen, 0);

    // mid-frame frame_start at cnt=100
    clear_counts();
    cyc(1, 0, '0, 1);
    for (int unsigned i = 0; i < 100; i++) cyc(0, 1, DW'(i), 1);
    cyc(1, 1, DW'(555), 1);
    for (int unsigned i = 0; i < 10; i++) cyc(0, 1, DW'(999), 1);
    drain();
    chk("mid_beats", beats, 101);
    chk("mid_errs", err_seen, 1);
    chk("mid_sops", sop_seen, 1);

    // async reset with 8 entries queued
    cyc(1, 0, '0, 0);
    for (int unsigned i = 0; i < 8; i++) cyc(0, 1, DW'(i + 1), 0);
    reset = 1;
    #1;
    chk("arst_valid", valid_out, 0);
    chk("arst_data", data_out, 0);
    chk("arst_sop", startofpacket_out, 0);
    chk("arst_eop", endofpacket_out, 0);
    chk("arst_err", frame_error_out, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    clear_counts();
    clean_frame(0);
    chk("post_rst_beats", beats, NPIX);
    chk("post_rst_sops", sop_seen, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(49) == 0, $urandom_range(3) != 0, DW'($urandom), $urandom_range(2) != 0);
    drain();
    chk("leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
